// File: rtl/inst_buf.sv
// Instruction buffer between fetch and decode.
// Circular FIFO; head entry is presented to decode.
module inst_buf #(
  parameter int ADDR  = 32,
  parameter int INST  = 32,
  parameter int DEPTH = 4,
  localparam int CNT  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            fetch_e_,
  input  logic [ADDR-1:0] fetch_pc,
  input  logic [INST-1:0] fetch_inst,
  input  logic            fetch_br_pred,
  output logic            buf_full,
  input  logic            dec_stall,
  input  logic            flush_,
  output logic            dec_e_,
  output logic [ADDR-1:0] dec_pc,
  output logic [INST-1:0] dec_inst,
  output logic            dec_br_pred,
  output logic [CNT-1:0]  count
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR-1:0] pc_q [DEPTH];
  logic [INST-1:0] inst_q [DEPTH];
  logic            bp_q [DEPTH];

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          valid;
  logic          push;
  logic          pop;

  assign valid    = (count != '0);
  assign buf_full = (count == CNT'(DEPTH));
  assign push     = ~fetch_e_ & ~buf_full & flush_;
  assign pop      = valid & ~dec_stall & flush_;

  assign dec_e_      = ~valid;
  assign dec_pc      = valid ? pc_q[rp]   : '0;
  assign dec_inst    = valid ? inst_q[rp] : '0;
  assign dec_br_pred = valid ? bp_q[rp]   : 1'b0;

  // Entry storage; contents only visible while occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wp]   <= fetch_pc;
      inst_q[wp] <= fetch_inst;
      bp_q[wp]   <= fetch_br_pred;
    end
  end

  // Pointers and occupancy; flush empties the buffer.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (!flush_) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT'(1);
        2'b01:   count <= count - CNT'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/inst_buf.md
INST_BUF -- requirements
Module: inst_buf

Interface
REQ-001 SHALL have parameter ADDR, default 32: PC width in bits.
REQ-002 SHALL have parameter INST, default 32: instruction word width in bits.
REQ-003 SHALL have parameter DEPTH, default 4: entry count; a power of two, at least 2.
REQ-004 SHALL have constant CNT = $clog2(DEPTH)+1, the occupancy width.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset_  in  1  asynchronous, active-low reset.
REQ-007 fetch_e_  in  1  active-low; fetch presents a valid instruction.
REQ-008 fetch_pc  in  ADDR  PC of the presented instruction.
REQ-009 fetch_inst  in  INST  presented instruction word.
REQ-010 fetch_br_pred  in  1  fetch predicted this instruction as a taken branch.
REQ-011 buf_full  out  1  buffer full; fetch SHALL stall while high.
REQ-012 dec_stall  in  1  decode cannot accept this cycle.
REQ-013 flush_  in  1  active-low; discard all entries (misprediction/exception redirect).
REQ-014 dec_e_  out  1  active-low; head entry valid to decode.
REQ-015 dec_pc  out  ADDR  head entry PC.
REQ-016 dec_inst  out  INST  head entry instruction.
REQ-017 dec_br_pred  out  1  head entry prediction bit.
REQ-018 count  out  CNT  number of valid entries, 0..DEPTH.

Function
REQ-019 SHALL be a circular FIFO: storage array, write pointer wp, read pointer rp (each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0), occupancy register count.
REQ-020 Push SHALL occur when fetch_e_=0, buf_full=0 and flush_=1: entry stored at wp, wp increments.
REQ-021 Pop SHALL occur when dec_e_=0, dec_stall=0 and flush_=1: rp increments.
REQ-022 buf_full SHALL be (count==DEPTH) from registered state only; no combinational path from dec_stall or fetch_e_ to buf_full.
REQ-023 A push attempted while buf_full=1 SHALL be ignored, even if a pop happens that cycle; the entry is not stored.
REQ-024 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-025 Push into an empty buffer SHALL produce dec_e_=0 on the following cycle; no same-cycle bypass (min latency 1 cycle).
REQ-026 dec_e_ SHALL be 0 exactly when count!=0; dec_pc, dec_inst and dec_br_pred SHALL equal the entry at rp when dec_e_=0, and all-zero when dec_e_=1.
REQ-027 A pop while count==0 SHALL NOT occur, since dec_e_=1; pointers are unaffected.
REQ-028 flush_=0 SHALL, at the next edge, set wp=rp=0 and count=0; same-cycle push and pop SHALL be suppressed; dec_e_=1 on the following cycle.
REQ-029 flush_ held low for multiple cycles SHALL keep the buffer empty and buf_full=0.
REQ-030 Entries SHALL be delivered in push order, with PC, instruction and prediction bit intact.
REQ-031 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-032 reset_=0 SHALL asynchronously clear wp, rp and count; dec_e_=1, buf_full=0, count=0 and data outputs 0 while reset_ is low.
REQ-033 Storage array contents need not be reset; they are never observable while count==0.
REQ-034 Reset asserted mid-operation SHALL discard all entries; the first push after release appears at dec_* one cycle later.

Verification
REQ-035 Reset, then push pc 0x100/inst 0x00000013 with dec_stall=0 -> next cycle dec_e_=0, dec_pc=0x100, dec_inst=0x00000013; cycle after, dec_e_=1, count=0.
REQ-036 dec_stall=1, push 4 entries (pc 0x0,0x4,0x8,0xC), then try a 5th (0x10) -> buf_full=1, count=4, 0x10 dropped; release stall -> pops 0x0,0x4,0x8,0xC in order on 4 consecutive cycles.
REQ-037 Steady stream with push and pop every cycle for 10 cycles (pc 0x200 step 4) -> count stays 1, pointers wrap twice, output order matches input, no drop.
REQ-038 count=3, flush_=0 with a concurrent push of pc 0x300 -> next cycle count=0, dec_e_=1; pc 0x300 never appears at dec_pc.
REQ-039 count=2, reset_ pulsed low between edges -> dec_e_=1 and count=0 immediately; after release, push pc 0x40 with br_pred=1 -> dec_pc=0x40, dec_br_pred=1 one cycle later.
REQ-040 count=4 (full), simultaneous pop and attempted push -> count=3 next cycle, pushed entry not stored.
